// File: rtl/gpio_bank_defines.sv
// Shared register map and bus constants for the GPIO bank array.
// Optional debounce register is enabled with GPIO_DEBOUNCE_EN.
package gpio_bank_defines;

    localparam logic [7:0] GPIO_REG_OE         = 8'h00;
    localparam logic [7:0] GPIO_REG_OUTPUT     = 8'h04;
    localparam logic [7:0] GPIO_REG_INPUT      = 8'h08;
    localparam logic [7:0] GPIO_REG_SET        = 8'h0C;
    localparam logic [7:0] GPIO_REG_CLEAR      = 8'h10;
    localparam logic [7:0] GPIO_REG_TOGGLE     = 8'h14;
    localparam logic [7:0] GPIO_REG_RISE_EN    = 8'h18;
    localparam logic [7:0] GPIO_REG_FALL_EN    = 8'h1C;
    localparam logic [7:0] GPIO_REG_IRQ_STATUS = 8'h20;
    localparam logic [7:0] GPIO_REG_DEBOUNCE   = 8'h24;

    localparam int BANK_LSB = 12;
    localparam int BANK_MSB = 15;

    localparam logic [31:0] UNMAPPED_READ = ~32'b0;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_bank_channel.sv
// One GPIO bank: registers, input synchroniser, edge interrupts.
// GPIO_DEBOUNCE_EN adds a per-bank sample filter on the input path.
module gpio_bank_channel
    import gpio_bank_defines::*;
#(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sel,
    input  logic         we,
    input  logic         oe,
    input  logic [7:0]   off,
    input  logic [3:0]   be,
    input  logic [31:0]  wdata,
    input  logic [W-1:0] pad,
    output logic         rd_hit,
    output logic [31:0]  rd_data,
    output logic [W-1:0] out_q,
    output logic [W-1:0] oe_q,
    output logic         irq
);

    logic [31:0]  lm;
    logic [31:0]  ld;
    logic [W-1:0] m;
    logic [W-1:0] d;
    logic         wr;
    logic         unused_hi;

    assign lm        = lane_mask(be);
    assign ld        = lm & wdata;
    assign m         = lm[W-1:0];
    assign d         = ld[W-1:0];
    assign wr        = sel & we;
    assign unused_hi = ^{lm, ld};

    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] status;
    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;
    logic [W-1:0] in_val;
    logic [W-1:0] w1c;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    assign w1c  = (wr && off == GPIO_REG_IRQ_STATUS) ? d : '0;
    assign rise = in_val & ~prev;
    assign fall = ~in_val & prev;
    assign irq  = |status;

`ifdef GPIO_DEBOUNCE_EN
    logic [7:0]   deb_q;
    logic [7:0]   cnt;
    logic [W-1:0] samp;
    logic [W-1:0] filt;
    logic [W-1:0] eq;
    logic         tick;

    assign tick   = cnt >= deb_q;
    assign eq     = ~(sync2 ^ samp);
    assign in_val = filt;

    // samp holds the value sync2 takes right after a tick; the next
    // tick compares it with sync2 just before that edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q <= '0;
            cnt   <= '0;
            samp  <= '0;
            filt  <= '0;
        end else begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
            if (tick) begin
                samp <= sync1;
                filt <= (filt & ~eq) | (sync2 & eq);
            end
            if (wr && off == GPIO_REG_DEBOUNCE)
                deb_q <= (deb_q & ~lm[7:0]) | ld[7:0];
        end
    end
`else
    assign in_val = sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oe_q    <= '0;
            out_q   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
        end else begin
            sync1  <= pad;
            sync2  <= sync1;
            prev   <= in_val;
            // a fresh edge wins over a same-cycle clear
            status <= (status & ~w1c) | (rise & rise_en) | (fall & fall_en);
            if (wr) begin
                case (off)
                    GPIO_REG_OE:      oe_q    <= (oe_q & ~m) | d;
                    GPIO_REG_OUTPUT:  out_q   <= (out_q & ~m) | d;
                    GPIO_REG_SET:     out_q   <= out_q | d;
                    GPIO_REG_CLEAR:   out_q   <= out_q & ~d;
                    GPIO_REG_TOGGLE:  out_q   <= out_q ^ d;
                    GPIO_REG_RISE_EN: rise_en <= (rise_en & ~m) | d;
                    GPIO_REG_FALL_EN: fall_en <= (fall_en & ~m) | d;
                    default: ;
                endcase
            end
        end
    end

    logic valid;

    always_comb begin
        rd_data = '0;
        valid   = 1'b1;
        case (off)
            GPIO_REG_OE:         rd_data = 32'(oe_q);
            GPIO_REG_OUTPUT:     rd_data = 32'(out_q);
            GPIO_REG_INPUT:      rd_data = 32'(in_val);
            GPIO_REG_SET:        rd_data = '0;
            GPIO_REG_CLEAR:      rd_data = '0;
            GPIO_REG_TOGGLE:     rd_data = '0;
            GPIO_REG_RISE_EN:    rd_data = 32'(rise_en);
            GPIO_REG_FALL_EN:    rd_data = 32'(fall_en);
            GPIO_REG_IRQ_STATUS: rd_data = 32'(status);
`ifdef GPIO_DEBOUNCE_EN
            GPIO_REG_DEBOUNCE:   rd_data = {24'b0, deb_q};
`endif
            default:             valid   = 1'b0;
        endcase
    end

    assign rd_hit = sel & oe & valid;

endmodule

// File: rtl/gpio_bank_array.sv
// BANK_COUNT GPIO banks behind one peripheral-bus slot, bank 0 at LSBs.
// Define GPIO_DEBOUNCE_EN to add the per-bank input debounce filter.
module gpio_bank_array
    import gpio_bank_defines::*;
#(
    parameter logic [7:0] ID         = 8'h03,
    parameter int         BANK_COUNT = 2,
    parameter int         BANK_WIDTH = 19
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             peripheralBus_we,
    input  logic                             peripheralBus_oe,
    output logic                             peripheralBus_busy,
    input  logic [23:0]                      peripheralBus_address,
    input  logic [3:0]                       peripheralBus_byteSelect,
    input  logic [31:0]                      peripheralBus_dataWrite,
    output logic [31:0]                      peripheralBus_dataRead,
    output logic                             requestOutput,
    input  logic [BANK_COUNT*BANK_WIDTH-1:0] gpio_input,
    output logic [BANK_COUNT*BANK_WIDTH-1:0] gpio_output,
    output logic [BANK_COUNT*BANK_WIDTH-1:0] gpio_oe,
    output logic                             irq,
    output logic [BANK_COUNT-1:0]            irq_bank
);

    logic                  id_hit;
    logic                  unused_addr;
    logic [BANK_COUNT-1:0] hit;
    logic [31:0]           bank_rd [BANK_COUNT];

    assign id_hit      = peripheralBus_address[23:16] == ID;
    assign unused_addr = ^peripheralBus_address[11:8];

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic sel;

        assign sel = id_hit &&
            (peripheralBus_address[BANK_MSB:BANK_LSB] == 4'(b + 1));

        gpio_bank_channel #(
            .W(BANK_WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .sel    (sel),
            .we     (peripheralBus_we),
            .oe     (peripheralBus_oe),
            .off    (peripheralBus_address[7:0]),
            .be     (peripheralBus_byteSelect),
            .wdata  (peripheralBus_dataWrite),
            .pad    (gpio_input[b*BANK_WIDTH +: BANK_WIDTH]),
            .rd_hit (hit[b]),
            .rd_data(bank_rd[b]),
            .out_q  (gpio_output[b*BANK_WIDTH +: BANK_WIDTH]),
            .oe_q   (gpio_oe[b*BANK_WIDTH +: BANK_WIDTH]),
            .irq    (irq_bank[b])
        );
    end

    // lowest bank wins, so walk from the top down
    always_comb begin
        peripheralBus_dataRead = UNMAPPED_READ;
        for (int b = BANK_COUNT - 1; b >= 0; b--) begin
            if (hit[b])
                peripheralBus_dataRead = bank_rd[b];
        end
    end

    assign requestOutput      = |hit;
    assign peripheralBus_busy = 1'b0;
    assign irq                = |irq_bank;

endmodule
